// File: rtl/delay_sched_pkg.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : delay_sched_pkg
// Purpose  : Shared constants, FSM state encoding and a width helper for the
//            delay scheduler and its round-robin arbiter.
// Ports    : none (package)
// Revision : 1.0 - initial release
// ============================================================================
package delay_sched_pkg;

  localparam int C_NREQ_DEFAULT  = 4;
  localparam int C_DW_DEFAULT    = 16;
  localparam int C_RATIO_DEFAULT = 1000;

  // Scheduler FSM encoding, explicit 2-bit width.
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_COUNT = 2'd1,
    ST_DONE  = 2'd2
  } state_t;

  // ceil(log2(v)), but never less than one bit so a counter that only ever
  // holds 0 (v == 1) still has a legal declaration.
  function automatic int clog2_min1(input int v);
    return (v > 1) ? $clog2(v) : 1;
  endfunction

endpackage : delay_sched_pkg
`default_nettype wire

// File: rtl/delay_sched_rr_arbiter.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : rr_arbiter
// Purpose  : Combinational round-robin picker. Searches the request vector
//            starting at the requester after last_i and returns the first
//            active one as a one-hot pick.
// Ports    : req_i   - request level per requester
//            last_i  - index of the requester served most recently
//            pick_o  - one-hot selected requester (zero when none)
//            valid_o - high when pick_o is nonzero
// Revision : 1.0 - initial release
// ============================================================================
module rr_arbiter
  import delay_sched_pkg::*;
#(
  parameter int NREQ = C_NREQ_DEFAULT,
  parameter int IW   = clog2_min1(NREQ)
) (
  input  logic [NREQ-1:0] req_i,
  input  logic [IW-1:0]   last_i,
  output logic [NREQ-1:0] pick_o,
  output logic            valid_o
);

  logic [IW-1:0] w_idx;

  // Offsets 1..NREQ walk every requester once, ending on last_i itself, so a
  // lone requester that was just served can still be picked again.
  always_comb begin
    pick_o  = '0;
    valid_o = 1'b0;
    w_idx   = '0;
    for (int off = 1; off <= NREQ; off++) begin
      w_idx = IW'((int'(last_i) + off) % NREQ);
      if (!valid_o && req_i[w_idx]) begin
        pick_o[w_idx] = 1'b1;
        valid_o       = 1'b1;
      end
    end
  end

endmodule : rr_arbiter
`default_nettype wire

// File: rtl/delay_sched.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : delay_sched
// Purpose  : Shares one countdown timer between NREQ requesters. A granted
//            requester waits delay*RATIO cycles, then receives a one-cycle
//            done pulse. Also provides a free-running unit tick and a count
//            of elapsed time units.
// Ports    : clk        - clock, rising edge
//            rst_n      - asynchronous active-low reset
//            req        - level request per requester
//            delay      - per-requester delay, lane i at [i*DW +: DW]
//            grant      - one-hot current timer owner
//            done       - one-hot completion pulse
//            busy       - timer owned
//            tick       - one-cycle pulse every RATIO cycles
//            unit_count - time units since reset (wraps at 2^32)
// Revision : 1.0 - initial release
// ============================================================================
module delay_sched
  import delay_sched_pkg::*;
#(
  parameter int NREQ  = C_NREQ_DEFAULT,
  parameter int DW    = C_DW_DEFAULT,
  parameter int RATIO = C_RATIO_DEFAULT
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [NREQ-1:0]    req,
  input  logic [NREQ*DW-1:0] delay,
  output logic [NREQ-1:0]    grant,
  output logic [NREQ-1:0]    done,
  output logic               busy,
  output logic               tick,
  output logic [31:0]        unit_count
);

  localparam int            PW          = clog2_min1(RATIO);
  localparam int            IW          = clog2_min1(NREQ);
  localparam logic [PW-1:0] C_PREC_LAST = PW'(RATIO - 1);
  localparam logic [IW-1:0] C_IDX_LAST  = IW'(NREQ - 1);

  state_t          state_q, state_d;
  logic [PW-1:0]   presc_q, presc_d;
  logic [31:0]     unit_count_q;
  logic [PW-1:0]   prec_q, prec_d;
  logic [DW-1:0]   remain_q, remain_d;
  logic [IW-1:0]   owner_q, owner_d;
  logic [IW-1:0]   last_q, last_d;

  logic [NREQ-1:0] w_pick;
  logic            w_pick_valid;
  logic [IW-1:0]   w_pick_idx;
  logic [DW-1:0]   w_pick_delay;
  logic            w_presc_wrap;
  logic            w_prec_wrap;

  // --------------------------------------------------------------------------
  // Free-running prescaler and unit counter
  // --------------------------------------------------------------------------
  assign w_presc_wrap = (presc_q == C_PREC_LAST);
  assign presc_d      = w_presc_wrap ? '0 : presc_q + 1'b1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      presc_q      <= '0;
      unit_count_q <= '0;
    end else begin
      presc_q <= presc_d;
      if (w_presc_wrap) begin
        unit_count_q <= unit_count_q + 32'd1;
      end
    end
  end

  // With RATIO == 1 the wrap condition is always true, so gate with rst_n to
  // keep tick low while reset is held.
  assign tick       = rst_n & w_presc_wrap;
  assign unit_count = unit_count_q;

  // --------------------------------------------------------------------------
  // Round-robin selection
  // --------------------------------------------------------------------------
  rr_arbiter #(
    .NREQ (NREQ),
    .IW   (IW)
  ) u_arb (
    .req_i   (req),
    .last_i  (last_q),
    .pick_o  (w_pick),
    .valid_o (w_pick_valid)
  );

  // One-hot pick to index, and the matching delay lane.
  always_comb begin
    w_pick_idx   = '0;
    w_pick_delay = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (w_pick[i]) begin
        w_pick_idx   = IW'(i);
        w_pick_delay = delay[i*DW +: DW];
      end
    end
  end

  // --------------------------------------------------------------------------
  // FSM: state register
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Timer datapath registers; last_q resets to the top index so the first
  // search starts at requester 0.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prec_q   <= '0;
      remain_q <= '0;
      owner_q  <= '0;
      last_q   <= C_IDX_LAST;
    end else begin
      prec_q   <= prec_d;
      remain_q <= remain_d;
      owner_q  <= owner_d;
      last_q   <= last_d;
    end
  end

  // --------------------------------------------------------------------------
  // FSM: next-state and datapath update
  // --------------------------------------------------------------------------
  assign w_prec_wrap = (prec_q == C_PREC_LAST);

  always_comb begin
    state_d  = state_q;
    prec_d   = prec_q;
    remain_d = remain_q;
    owner_d  = owner_q;
    last_d   = last_q;
    unique case (state_q)
      ST_IDLE: begin
        if (w_pick_valid) begin
          owner_d  = w_pick_idx;
          remain_d = w_pick_delay;
          prec_d   = '0;
          state_d  = (w_pick_delay != '0) ? ST_COUNT : ST_DONE;
        end
      end
      ST_COUNT: begin
        if (!req[owner_q]) begin
          // Owner withdrew: release the timer silently; it still counts as
          // served so the next search moves past it.
          state_d = ST_IDLE;
          last_d  = owner_q;
        end else if (w_prec_wrap) begin
          prec_d   = '0;
          remain_d = remain_q - 1'b1;
          if (remain_q == DW'(1)) begin
            state_d = ST_DONE;
          end
        end else begin
          prec_d = prec_q + 1'b1;
        end
      end
      ST_DONE: begin
        last_d  = owner_q;
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // --------------------------------------------------------------------------
  // FSM: outputs
  // --------------------------------------------------------------------------
  always_comb begin
    grant = '0;
    done  = '0;
    busy  = 1'b0;
    unique case (state_q)
      ST_COUNT: begin
        grant[owner_q] = 1'b1;
        busy           = 1'b1;
      end
      ST_DONE: begin
        grant[owner_q] = 1'b1;
        done[owner_q]  = 1'b1;
        busy           = 1'b1;
      end
      default: begin
        grant = '0;
      end
    endcase
  end

endmodule : delay_sched
`default_nettype wire

// File: tb/tb_delay_sched.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_delay_sched
// Purpose  : Self-checking bench for delay_sched (NREQ=4, DW=8, RATIO=4).
//            Expected done events are queued when a grant is observed and
//            matched by a monitor when done pulses.
// Ports    : none
// Revision : 1.0 - initial release
// ============================================================================
module tb_delay_sched;

  localparam int NREQ  = 4;
  localparam int DW    = 8;
  localparam int RATIO = 4;

  logic        clk   = 1'b0;
  logic        rst_n = 1'b0;
  logic [3:0]  req   = '0;
  logic [31:0] delay = '0;
  logic [3:0]  grant;
  logic [3:0]  done;
  logic        busy;
  logic        tick;
  logic [31:0] unit_count;

  delay_sched #(
    .NREQ  (NREQ),
    .DW    (DW),
    .RATIO (RATIO)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req        (req),
    .delay      (delay),
    .grant      (grant),
    .done       (done),
    .busy       (busy),
    .tick       (tick),
    .unit_count (unit_count)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc++;

  int checks   = 0;
  int failures = 0;

  typedef struct {
    int idx;
    int cyc;
  } exp_t;

  typedef struct {
    logic [3:0]  req;
    logic [31:0] delay;
    int          exp_idx;
    int          exp_d;
  } vec_t;

  exp_t sb_q[$];
  exp_t mon_e;
  vec_t vecs[5];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h, want 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Scoreboard monitor: samples just after the falling edge so the main
  // process has already queued any expectation for this cycle.
  always @(negedge clk) begin
    #1;
    checks++;
    if (!($onehot0(grant) && $onehot0(done))) begin
      failures++;
      $display("FAIL onehot: got grant=%b done=%b, want one-hot or zero", grant, done);
    end
    if (done != 4'b0000) begin
      if (sb_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_done: got done=%b at cycle %0d, want none", done, cyc);
      end else begin
        mon_e = sb_q.pop_front();
        check("done_idx", {28'b0, done}, 32'(1 << mon_e.idx));
        check("done_cycle", cyc, mon_e.cyc);
      end
    end
  end

  task automatic wait_grant(output int n);
    n = 0;
    while (grant == 4'b0000 && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (grant == 4'b0000) begin
      checks++;
      failures++;
      $display("FAIL grant_timeout: got no grant in %0d cycles, want grant", n);
    end
  endtask

  // One grant/done transaction. Expects the grant exactly one cycle after the
  // call (caller is in an IDLE cycle with the request visible).
  task automatic serve(input int exp_idx, input int d, input bit drop, input bit scramble);
    int  n;
    int  g;
    bit  seen;
    wait_grant(n);
    g = cyc;
    check("grant_wait", n, 1);
    check("grant_idx", {28'b0, grant}, 32'(1 << exp_idx));
    check("busy_on", {31'b0, busy}, 1);
    sb_q.push_back('{idx: exp_idx, cyc: g + d * RATIO});
    if (scramble) delay = ~delay;
    seen = 1'b0;
    for (int k = 0; k <= d * RATIO + 4 && !seen; k++) begin
      if (done != 4'b0000) seen = 1'b1;
      else @(negedge clk);
    end
    if (!seen) begin
      checks++;
      failures++;
      $display("FAIL done_timeout: got no done for idx %0d, want done at %0d", exp_idx, g + d * RATIO);
    end
    if (drop) req = 4'b0000;
    @(negedge clk);
    check("grant_off", {28'b0, grant}, 0);
    check("busy_off", {31'b0, busy}, 0);
  endtask

  initial begin
    int n;

    // Reset state
    repeat (3) @(negedge clk);
    check("rst_grant", {28'b0, grant}, 0);
    check("rst_done", {28'b0, done}, 0);
    check("rst_busy", {31'b0, busy}, 0);
    check("rst_tick", {31'b0, tick}, 0);
    check("rst_unit_count", unit_count, 0);

    // Idle prescaler: tick on every 4th cycle, 5 units after 20 cycles
    rst_n = 1'b1;
    for (int k = 1; k <= 20; k++) begin
      @(negedge clk);
      check("tick_idle", {31'b0, tick}, {31'b0, (k % 4) == 3});
    end
    check("unit_count_20", unit_count, 5);

    // Table of single-shot transactions; pointer walks 3 -> 0 -> 2 -> 3 -> 1 -> 3
    vecs[0] = '{req: 4'b0001, delay: 32'h0000_000A, exp_idx: 0, exp_d: 10};
    vecs[1] = '{req: 4'b0100, delay: 32'h0500_0703, exp_idx: 2, exp_d: 0};
    vecs[2] = '{req: 4'b1010, delay: 32'h0209_0309, exp_idx: 3, exp_d: 2};
    vecs[3] = '{req: 4'b1010, delay: 32'h0209_0309, exp_idx: 1, exp_d: 3};
    vecs[4] = '{req: 4'b1000, delay: 32'h0100_0000, exp_idx: 3, exp_d: 1};
    for (int v = 0; v < 5; v++) begin
      req   = vecs[v].req;
      delay = vecs[v].delay;
      serve(vecs[v].exp_idx, vecs[v].exp_d, 1'b1, 1'b1);
    end

    // All requesting with delay 1: rotation 0,1,2,3,0
    req   = 4'b1111;
    delay = 32'h0101_0101;
    for (int i = 0; i < 5; i++) begin
      serve(i % 4, 1, i == 4, 1'b0);
    end

    // Requester 1 withdraws 7 cycles after grant; requester 2 follows
    req   = 4'b0110;
    delay = 32'h0002_0500;
    wait_grant(n);
    check("abort_wait", n, 1);
    check("abort_grant", {28'b0, grant}, 32'b0010);
    repeat (7) @(negedge clk);
    req = 4'b0100;
    @(negedge clk);
    check("abort_grant_off", {28'b0, grant}, 0);
    check("abort_busy_off", {31'b0, busy}, 0);
    check("abort_no_done", {28'b0, done}, 0);
    serve(2, 2, 1'b1, 1'b0);

    // One-cycle reset in the middle of a count
    req   = 4'b0001;
    delay = 32'h0000_000A;
    wait_grant(n);
    check("rstc_grant", {28'b0, grant}, 32'b0001);
    repeat (5) @(negedge clk);
    rst_n = 1'b0;
    req   = 4'b0000;
    #1;
    check("rstc_grant_off", {28'b0, grant}, 0);
    check("rstc_busy_off", {31'b0, busy}, 0);
    check("rstc_unit_count", unit_count, 0);
    check("rstc_done", {28'b0, done}, 0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int k = 1; k <= 4; k++) begin
      @(negedge clk);
      check("tick_after_rst", {31'b0, tick}, {31'b0, k == 3});
    end
    check("unit_count_after_rst", unit_count, 1);
    repeat (45) @(negedge clk);

    check("scoreboard_empty", sb_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule : tb_delay_sched
`default_nettype wire
